// File: rtl/stim_pkg.sv
// Shared types and default parameters for the stimulus sequencer and its op queue.
package stim_pkg;

  typedef enum logic [1:0] {
    CMD_BLK = 2'd0,
    CMD_NB  = 2'd1,
    LEAN    = 2'd2,
    WAIT    = 2'd3
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [15:0] data;
  } entry_t;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SEND,
    S_PULSE,
    S_WAIT
  } state_t;

  localparam int unsigned DEF_DEPTH      = 8;
  localparam int unsigned DEF_LEAN_W     = 16;
  localparam int unsigned DEF_WAIT_SHIFT = 4;
  localparam int unsigned DEF_RST_CYCLES = 10;
  localparam int unsigned DEF_TIMEOUT    = 1_000_000;
  localparam int unsigned CNT_W          = 32;

endpackage

// File: rtl/stim_fifo.sv
// DEPTH-entry show-ahead FIFO of stimulus ops; a push while full is accepted
// only when a pop happens in the same cycle.
module stim_fifo import stim_pkg::*; #(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  entry_t        mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d  = wptr_q + PW'(do_push);
    rptr_d  = rptr_q + PW'(do_pop);
    rdata   = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/stim_sequencer.sv
// Queue-driven stimulus engine: DUT reset release, UART command sends, lean steps
// and timed waits. Define STIM_TIMEOUT_EN to build the blocking-send timeout.
module stim_sequencer import stim_pkg::*; #(
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned LEAN_W     = DEF_LEAN_W,
  parameter int unsigned WAIT_SHIFT = DEF_WAIT_SHIFT,
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              RST_n,
  input  logic              push,
  input  logic [1:0]        push_op,
  input  logic [LEAN_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              busy,
  output logic              err,
  output logic              dut_rst_n,
  output logic [7:0]        cmd,
  output logic              send_cmd,
  input  logic              cmd_sent,
  output logic [LEAN_W-1:0] rider_lean
);

  entry_t            push_entry;
  entry_t            head;
  logic              pop;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  wait_len;
  logic              dut_rst_n_q, dut_rst_n_d;
  logic [7:0]        cmd_q, cmd_d;
  logic              send_cmd_q, send_cmd_d;
  logic [LEAN_W-1:0] lean_q, lean_d;
  logic              ovf_q, ovf_d;
  logic              sent_sync_q, sent_prev_q;
  logic              sent_rise;
`ifdef STIM_TIMEOUT_EN
  logic              err_q, err_d;
`endif

  always_comb begin
    push_entry.op   = op_t'(push_op);
    push_entry.data = 16'(push_data);
  end

  stim_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (RST_n),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dut_rst_n_d = dut_rst_n_q;
    cmd_d       = cmd_q;
    send_cmd_d  = send_cmd_q;
    lean_d      = lean_q;
`ifdef STIM_TIMEOUT_EN
    err_d       = err_q;
`endif
    pop         = 1'b0;
    sent_rise   = sent_sync_q && !sent_prev_q;
    wait_len    = CNT_W'(head.data) << WAIT_SHIFT;

    unique case (state_q)
      S_INIT: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d     = S_IDLE;
          dut_rst_n_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          cnt_d = '0;
          case (head.op)
            CMD_BLK: begin
              cmd_d      = head.data[7:0];
              send_cmd_d = 1'b1;
              state_d    = S_SEND;
            end
            CMD_NB: begin
              cmd_d      = head.data[7:0];
              send_cmd_d = 1'b1;
              state_d    = S_PULSE;
            end
            LEAN: lean_d = LEAN_W'($signed(head.data));
            WAIT: begin
              // A zero-length wait stays in IDLE so the next pop follows directly.
              cnt_d = wait_len;
              if (wait_len != '0) state_d = S_WAIT;
            end
          endcase
        end
      end
      S_SEND: begin
        if (sent_rise) begin
          send_cmd_d = 1'b0;
          state_d    = S_IDLE;
        end
`ifdef STIM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          send_cmd_d = 1'b0;
          err_d      = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_PULSE: begin
        send_cmd_d = 1'b0;
        state_d    = S_IDLE;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_INIT;
    endcase

    ovf_d = ovf_q || (push && full && !pop);
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      dut_rst_n_q <= 1'b0;
      cmd_q       <= '0;
      send_cmd_q  <= 1'b0;
      lean_q      <= '0;
      ovf_q       <= 1'b0;
      sent_sync_q <= 1'b0;
      sent_prev_q <= 1'b0;
`ifdef STIM_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dut_rst_n_q <= dut_rst_n_d;
      cmd_q       <= cmd_d;
      send_cmd_q  <= send_cmd_d;
      lean_q      <= lean_d;
      ovf_q       <= ovf_d;
      sent_sync_q <= cmd_sent;
      sent_prev_q <= sent_sync_q;
`ifdef STIM_TIMEOUT_EN
      err_q       <= err_d;
`endif
    end
  end

`ifdef STIM_TIMEOUT_EN
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err = 1'b0;
`endif

  assign dut_rst_n  = dut_rst_n_q;
  assign cmd        = cmd_q;
  assign send_cmd   = send_cmd_q;
  assign rider_lean = lean_q;
  assign ovf        = ovf_q;
  assign busy       = ((state_q != S_IDLE) && (state_q != S_INIT)) || !empty;

endmodule

// File: tb/tb_stim_sequencer.sv
// Bench for stim_sequencer: directed phases plus random traffic against an
// edge-indexed reference model of the op queue. Honours STIM_TIMEOUT_EN.
module tb_stim_sequencer;
  import stim_pkg::*;

  localparam int DEPTH      = 8;
  localparam int LEAN_W     = 16;
  localparam int WAIT_SHIFT = 4;
  localparam int RST_CYCLES = 10;
  localparam int TIMEOUT    = 100;

  logic        clk = 1'b0;
  logic        RST_n = 1'b1;
  logic        push = 1'b0;
  logic [1:0]  push_op = 2'd0;
  logic [15:0] push_data = 16'd0;
  logic        cmd_sent = 1'b0;
  logic        full, empty, ovf, busy, err, dut_rst_n, send_cmd;
  logic [7:0]  cmd;
  logic [15:0] rider_lean;

  stim_sequencer #(
    .DEPTH(DEPTH), .LEAN_W(LEAN_W), .WAIT_SHIFT(WAIT_SHIFT),
    .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .RST_n(RST_n), .push(push), .push_op(push_op), .push_data(push_data),
    .full(full), .empty(empty), .ovf(ovf), .busy(busy), .err(err),
    .dut_rst_n(dut_rst_n), .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
    .rider_lean(rider_lean)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { int op; int data; } m_entry_t;
  m_entry_t    mq[$];
  int          m_e, next_pop, blk_start, nb_edge;
  bit          blk, m_ovf, m_err, s1, s2;
  logic [7:0]  m_cmd;
  logic [15:0] m_lean;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_e);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_e = 0; next_pop = RST_CYCLES + 1; blk_start = 0; nb_edge = -1;
    blk = 0; m_ovf = 0; m_err = 0; s1 = 0; s2 = 0;
    m_cmd = 8'h00; m_lean = 16'h0000;
  endtask

  // Edge E after release: a pop is allowed once E reaches next_pop and no send blocks.
  task automatic model_step();
    int E;
    m_entry_t h;
    E = m_e + 1;
    if (blk) begin
      if (s1 && !s2) begin
        blk = 0; next_pop = E + 1;
      end
`ifdef STIM_TIMEOUT_EN
      else if (E - blk_start == TIMEOUT) begin
        blk = 0; m_err = 1; next_pop = E + 1;
      end
`endif
    end
    if (!blk && E >= next_pop && mq.size() > 0) begin
      h = mq.pop_front();
      case (h.op)
        0: begin m_cmd = 8'(h.data); blk = 1; blk_start = E; end
        1: begin m_cmd = 8'(h.data); nb_edge = E; next_pop = E + 2; end
        2: begin m_lean = 16'(h.data); next_pop = E + 1; end
        default: next_pop = E + (h.data << WAIT_SHIFT) + 1;
      endcase
    end
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back('{op: int'(push_op), data: int'(push_data)});
      else m_ovf = 1;
    end
    s2 = s1; s1 = cmd_sent; m_e = E;
  endtask

  task automatic compare_model();
    chk("dut_rst_n", 32'(dut_rst_n), 32'(m_e >= RST_CYCLES));
    chk("send_cmd",  32'(send_cmd),  32'(blk || (nb_edge == m_e)));
    chk("cmd",       32'(cmd),       32'(m_cmd));
    chk("rider_lean",32'(rider_lean),32'(m_lean));
    chk("full",      32'(full),      32'(mq.size() == DEPTH));
    chk("empty",     32'(empty),     32'(mq.size() == 0));
    chk("ovf",       32'(ovf),       32'(m_ovf));
    chk("err",       32'(err),       32'(m_err));
    chk("busy",      32'(busy),
        32'((mq.size() > 0) || ((m_e >= RST_CYCLES) && (blk || (m_e < next_pop - 1)))));
  endtask

  task automatic tick();
    @(posedge clk);
    if (RST_n) model_step(); else model_reset();
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    RST_n = 1'b0; push = 1'b0;
    repeat (3) tick();
    RST_n = 1'b1;
  endtask

  task automatic set_push(input int op, input int data);
    push = 1'b1; push_op = 2'(op); push_data = 16'(data);
  endtask

  task automatic chk_reset_values();
    chk("rst dut_rst_n", 32'(dut_rst_n), 32'd0);
    chk("rst send_cmd",  32'(send_cmd),  32'd0);
    chk("rst cmd",       32'(cmd),       32'd0);
    chk("rst rider_lean",32'(rider_lean),32'd0);
    chk("rst full",      32'(full),      32'd0);
    chk("rst empty",     32'(empty),     32'd1);
    chk("rst ovf",       32'(ovf),       32'd0);
    chk("rst err",       32'(err),       32'd0);
    chk("rst busy",      32'(busy),      32'd0);
  endtask

  initial begin
    model_reset();
    #1 RST_n = 1'b0;
    @(negedge clk);
    chk_reset_values();
    do_reset();

    // Phase A: queue limits during INIT, reset release, NB/LEAN/WAIT timing.
    for (int k = 1; k <= 72; k++) begin
      push = 1'b0;
      case (k)
        1: set_push(2, 16'h0FFF);
        2: set_push(1, 16'h00A5);
        3: set_push(2, 16'hFF00);
        4: set_push(3, 3);
        5: set_push(3, 0);
        6: set_push(2, 16'h1234);
        7: set_push(2, 16'h0002);
        8: set_push(1, 16'h003C);
        9: set_push(2, 16'h7777);
        11: set_push(2, 16'h5555);
        default: ;
      endcase
      tick();
      case (k)
        8:  begin chk("A full after 8", 32'(full), 32'd1); chk("A ovf before drop", 32'(ovf), 32'd0); end
        9:  begin chk("A ovf after drop", 32'(ovf), 32'd1); chk("A dut_rst_n at 9", 32'(dut_rst_n), 32'd0);
                  chk("A lean in INIT", 32'(rider_lean), 32'd0); end
        10: begin chk("A dut_rst_n at 10", 32'(dut_rst_n), 32'd1); chk("A lean at 10", 32'(rider_lean), 32'd0); end
        11: begin chk("A first lean", 32'(rider_lean), 32'h0FFF); chk("A full push+pop", 32'(full), 32'd1); end
        12: begin chk("A nb send", 32'(send_cmd), 32'd1); chk("A nb cmd", 32'(cmd), 32'hA5); end
        13: chk("A nb send low", 32'(send_cmd), 32'd0);
        14: chk("A lean -256", 32'(rider_lean), 32'hFF00);
        64: chk("A lean before wait end", 32'(rider_lean), 32'hFF00);
        65: chk("A lean after 49+1", 32'(rider_lean), 32'h1234);
        66: chk("A lean back-to-back", 32'(rider_lean), 32'h0002);
        67: chk("A nb cmd 3C", 32'(cmd), 32'h3C);
        69: begin chk("A late lean", 32'(rider_lean), 32'h5555); chk("A drained", 32'(empty), 32'd1); end
        72: chk("A dropped never runs", 32'(rider_lean), 32'h5555);
        default: ;
      endcase
    end

    // Phase B: blocking send ignores an already-high cmd_sent, needs a fresh rise.
    cmd_sent = 1'b1;
    do_reset();
    for (int k = 1; k <= 56; k++) begin
      push = 1'b0;
      cmd_sent = (k <= 40 || k >= 50);
      if (k == 12) set_push(0, 16'h0011);
      if (k == 20) set_push(2, 16'h0042);
      tick();
      case (k)
        13: begin chk("B send high", 32'(send_cmd), 32'd1); chk("B cmd", 32'(cmd), 32'h11); end
        40: chk("B held level", 32'(send_cmd), 32'd1);
        50: chk("B before detect", 32'(send_cmd), 32'd1);
        51: chk("B fall after rise", 32'(send_cmd), 32'd0);
        52: chk("B next op", 32'(rider_lean), 32'h0042);
        default: ;
      endcase
    end

`ifdef STIM_TIMEOUT_EN
    // Phase C: stuck cmd_sent low times out after TIMEOUT cycles.
    cmd_sent = 1'b0;
    do_reset();
    for (int k = 1; k <= 115; k++) begin
      push = 1'b0;
      if (k == 1) set_push(0, 16'h0022);
      if (k == 2) set_push(2, 16'h0033);
      tick();
      case (k)
        110: begin chk("C send pre-timeout", 32'(send_cmd), 32'd1); chk("C err pre", 32'(err), 32'd0); end
        111: begin chk("C send timeout", 32'(send_cmd), 32'd0); chk("C err set", 32'(err), 32'd1); end
        112: chk("C next op", 32'(rider_lean), 32'h0033);
        default: ;
      endcase
    end
`endif

    // Phase D: random traffic against the model.
    cmd_sent = 1'b0;
    do_reset();
    for (int k = 1; k <= 1500; k++) begin
      int op;
      push = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        op = int'($urandom_range(0, 3));
        set_push(op, (op == 3) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 65535)));
      end
      if ($urandom_range(0, 7) == 0) cmd_sent = ~cmd_sent;
      tick();
    end

    // Phase E: asynchronous reset in the middle of a WAIT.
    cmd_sent = 1'b0;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      push = 1'b0;
      if (k == 1) set_push(2, 16'h0101);
      if (k == 2) set_push(1, 16'h0077);
      if (k == 3) set_push(3, 5);
      tick();
    end
    push = 1'b0;
    chk("E busy in wait", 32'(busy), 32'd1);
    chk("E lean before reset", 32'(rider_lean), 32'h0101);
    chk("E cmd before reset", 32'(cmd), 32'h77);
    #2 RST_n = 1'b0;
    #1 chk_reset_values();
    model_reset();
    repeat (2) tick();
    RST_n = 1'b1;
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
